// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encodings,
// default pattern size and the width helper for the length field.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int MAX_LEN_DEF = 8;

   // Length field must hold the value MAX_LEN itself, hence the extra bit.
   function automatic int len_w(input int max_len);
      return $clog2(max_len) + 1;
   endfunction

endpackage

// File: rtl/serial_pattern_tx_bit_timer.sv
// Per-bit hold counter: reloads on load or on terminal count while enabled,
// and emits the advance strobe on the last cycle of each bit.
module bit_timer #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tc,
   output logic             adv
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load || (en && tc))
         cnt <= div;
      else if (en)
         cnt <= cnt - DIV_W'(1);
   end

   assign tc  = (cnt == '0);
   assign adv = en && tc;

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial pattern transmitter with per-bit hold and pass repeat.
// Outputs decode only registered state, so inputs never reach w combinationally.
module serial_pattern_tx
   import serial_tx_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int DIV_W   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [MAX_LEN-1:0]          pattern,
   input  logic [len_w(MAX_LEN)-1:0]   len,
   input  logic [3:0]                  repeat_cnt,
   input  logic [DIV_W-1:0]            bit_div,
   output logic                        w,
   output logic                        w_valid,
   output logic                        busy,
   output logic                        done,
   output logic [1:0]                  states
);

   localparam int LW = len_w(MAX_LEN);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t            state, nxt;
   logic [MAX_LEN-1:0] pat_q;
   logic [LW-1:0]     len_q, len_cl;
   logic [IW-1:0]     idx, idx_top;
   logic [3:0]        rep_q, pass_q;
   logic [DIV_W-1:0]  div_q;
   logic              tm_load, tm_en, tm_tc, adv;

   assign len_cl  = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
   assign idx_top = IW'(len_q - LW'(1));
   assign tm_load = (state == LOAD);
   assign tm_en   = (state == SHIFT);

   bit_timer #(.DIV_W(DIV_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tm_load),
      .en    (tm_en),
      .div   (div_q),
      .tc    (tm_tc),
      .adv   (adv)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = LOAD;
         LOAD:    nxt = (len_q == '0) ? DONE : SHIFT;
         SHIFT:   if (adv && idx == '0 && pass_q == '0) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Inputs are captured once in IDLE; nothing downstream looks at them again.
   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q  <= '0;
         len_q  <= '0;
         rep_q  <= '0;
         div_q  <= '0;
         idx    <= '0;
         pass_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               pat_q <= pattern;
               len_q <= len_cl;
               rep_q <= repeat_cnt;
               div_q <= bit_div;
            end
            LOAD: begin
               idx    <= idx_top;
               pass_q <= rep_q;
            end
            SHIFT: if (adv) begin
               if (idx != '0) begin
                  idx <= idx - IW'(1);
               end else if (pass_q != '0) begin
                  pass_q <= pass_q - 4'd1;
                  idx    <= idx_top;
               end
            end
            default: ;
         endcase
      end
   end

   assign w       = (state == SHIFT) ? pat_q[idx] : 1'b0;
   assign w_valid = (state == SHIFT);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign states  = state;

endmodule
